// File: rtl/cla_serial_adder_pkg.sv
// Shared constants for the nibble-serial CLA adder.
// State encoding and slice width.
package cla_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_serial_adder_cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports: A, B, Cin -> Sum, Cout, C3 (carry into bit 3).
module cla4_slice (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       C3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = Cin;
  assign c[1] = g[0]
              | (p[0] & c[0]);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];
  assign C3   = c[3];

endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder streaming one nibble per clock through a CLA slice.
// Ports: clk, rst, in_valid/in_ready, a, b, cin, out_valid/out_ready, sum, cout, ovf, busy.
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             accept;
  logic             step;
  logic             last;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             s_cout;
  logic             s_c3;

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_nib = a_q[k*NIBBLE +: NIBBLE];
        b_nib = b_q[k*NIBBLE +: NIBBLE];
      end
    end
  end

  cla4_slice u_slice (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry),
    .Sum  (s_nib),
    .Cout (s_cout),
    .C3   (s_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cnt   <= '0;
      carry <= cin;
    end else if (step) begin
      carry <= s_cout;
      for (int k = 0; k < NSLICE; k++) begin
        if (cnt == CW'(k)) sum[k*NIBBLE +: NIBBLE] <= s_nib;
      end
      if (last) begin
        cout <= s_cout;
        ovf  <= s_c3 ^ s_cout;
        cnt  <= '0;
      end else if (NSLICE > 1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed self-checking bench for cla_serial_adder (WIDTH=16).
// Steps one initial block through handshakes, carries, overflow, backpressure and reset.
module tb_cla_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] av,
                       input logic [15:0] bv,
                       input logic        cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    chk("start_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_no_valid", 32'(out_valid), 32'd0);
    end
    tick();
    chk("done_valid", 32'(out_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic check_res(input string tag,
                           input logic [15:0] es,
                           input logic        ec,
                           input logic        eo);
    chk({tag, "_sum"},  32'(sum),  32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"},  32'(ovf),  32'(eo));
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_valid", 32'(out_valid), 32'd0);
    chk("handoff_ready", 32'(in_ready),  32'd1);
  endtask

  task automatic op(input string tag,
                    input logic [15:0] av,
                    input logic [15:0] bv,
                    input logic        cv,
                    input logic [15:0] es,
                    input logic        ec,
                    input logic        eo);
    start(av, bv, cv);
    run_to_done();
    check_res(tag, es, ec, eo);
    handoff();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    check_res("rst", 16'h0000, 1'b0, 1'b0);

    op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("prop", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("povf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("novf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    start(16'h1234, 16'h4321, 1'b1);
    a        = 16'hD0A0;
    b        = 16'hA0D0;
    cin      = 1'b0;
    in_valid = 1'b1;
    run_to_done();
    check_res("b2b1", 16'h5556, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready),  32'd0);
      check_res("bp", 16'h5556, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_handoff_valid", 32'(out_valid), 32'd0);
    chk("b2b_handoff_busy",  32'(busy),      32'd0);
    chk("b2b_handoff_ready", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_hold_sum", 32'(sum), 32'(16'h5556));
    run_to_done();
    check_res("b2b2", 16'h7170, 1'b1, 1'b1);
    handoff();

    start(16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    check_res("mid_rst", 16'h0000, 1'b0, 1'b0);

    op("post", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
